mmio_fifo_ctrl: RTL and testbench

MMIO_FIFO_CTRL -- requirements
Module: mmio_fifo_ctrl

---
 rtl/mmio_fifo_ctrl_if.sv | 32 +++
 rtl/mmio_fifo_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mmio_fifo_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_fifo_ctrl_if.sv
// MMIO request/response channel plus the side-channel to the shift-register FIFO.
// The slave modport is the controller; the master modport is its environment.
interface mmio_fifo_ctrl_if;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic        rd_valid;
    logic [15:0] rd_addr;
    logic [8:0]  rd_tid;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        fifo_en;
    logic [63:0] fifo_d;
    logic [63:0] fifo_q;

    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_valid, rd_addr, rd_tid,
        output fifo_q,
        input  rsp_valid, rsp_tid, rsp_data,
        input  fifo_en, fifo_d
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_addr, rd_tid,
        input  fifo_q,
        output rsp_valid, rsp_tid, rsp_data,
        output fifo_en, fifo_d
    );
endinterface

// File: rtl/mmio_fifo_ctrl.sv
// MMIO front-end for a shift-register FIFO: data pushes, flush sequencing,
// sticky overflow/drop flags and a status register readable over MMIO.
module mmio_fifo_ctrl #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [15:0] ADDR_DATA = 16'h0020,
    parameter logic [15:0] ADDR_STAT = 16'h0022,
    parameter logic [15:0] ADDR_CTRL = 16'h0024
) (
    input  logic            clk,
    input  logic            rst,
    mmio_fifo_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_e;

    localparam logic [7:0] DEPTH_C = 8'(DEPTH);
    localparam logic [7:0] LAST_C  = 8'(DEPTH - 1);

    state_e      state_q, state_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [7:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic        drop_q, drop_d;
    logic        pend_v_q, pend_v_d;
    logic [63:0] pend_q, pend_d;
    logic        fifo_en_q, fifo_en_d;
    logic [63:0] fifo_d_q, fifo_d_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [8:0]  rsp_tid_q, rsp_tid_d;
    logic [63:0] rsp_data_q, rsp_data_d;

    logic        wr_dat;
    logic        wr_ctl;
    logic        push;
    logic [63:0] push_val;
    logic [63:0] stat;

    assign wr_dat = bus.wr_valid && (bus.wr_addr == ADDR_DATA);
    assign wr_ctl = bus.wr_valid && (bus.wr_addr == ADDR_CTRL);

    assign stat = {51'd0, pend_v_q, drop_q, ovf_q,
                   state_q == FLUSH, count_q == DEPTH_C, count_q};

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        pend_v_d    = pend_v_q;
        pend_d      = pend_q;
        fifo_en_d   = 1'b0;
        fifo_d_d    = '0;
        push        = 1'b0;
        push_val    = '0;
        rsp_valid_d = bus.rd_valid;
        rsp_tid_d   = bus.rd_valid ? bus.rd_tid : '0;
        rsp_data_d  = '0;

        if (bus.rd_valid) begin
            if (bus.rd_addr == ADDR_DATA) begin
                rsp_data_d = bus.fifo_q;
            end else if (bus.rd_addr == ADDR_STAT) begin
                rsp_data_d = stat;
            end
        end

        // Clear first so a coinciding set event below takes precedence.
        if (wr_ctl && bus.wr_data[1]) begin
            ovf_d  = 1'b0;
            drop_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pend_v_q) begin
                    push     = 1'b1;
                    push_val = pend_q;
                    if (wr_dat) begin
                        pend_d = bus.wr_data;
                    end else begin
                        pend_v_d = 1'b0;
                    end
                end else if (wr_dat) begin
                    push     = 1'b1;
                    push_val = bus.wr_data;
                end else if (wr_ctl && bus.wr_data[0]) begin
                    state_d   = FLUSH;
                    fcnt_d    = '0;
                    fifo_en_d = 1'b1;
                end
            end
            FLUSH: begin
                if (fcnt_q == LAST_C) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    fcnt_d    = fcnt_q + 8'd1;
                    fifo_en_d = 1'b1;
                end
                if (wr_dat) begin
                    if (pend_v_q) begin
                        drop_d = 1'b1;
                    end else begin
                        pend_v_d = 1'b1;
                        pend_d   = bus.wr_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            fifo_en_d = 1'b1;
            fifo_d_d  = push_val;
            if (count_q == DEPTH_C) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_q      <= '0;
            fifo_en_q   <= 1'b0;
            fifo_d_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            pend_v_q    <= pend_v_d;
            pend_q      <= pend_d;
            fifo_en_q   <= fifo_en_d;
            fifo_d_q    <= fifo_d_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.fifo_en   = fifo_en_q;
    assign bus.fifo_d    = fifo_d_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_tid   = rsp_tid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Bench for mmio_fifo_ctrl: directed vector table, reset-abort sequence,
// then random traffic against a queue-based reference model.
module tb_mmio_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam logic [15:0] A_DAT = 16'h0020;
    localparam logic [15:0] A_STA = 16'h0022;
    localparam logic [15:0] A_CTL = 16'h0024;
    localparam logic [15:0] A_UNM = 16'h0030;
    localparam logic [15:0] NA    = 16'h0000;
    localparam logic [8:0]  NT    = 9'h000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mmio_fifo_ctrl_if bus ();

    mmio_fifo_ctrl #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The attached shift-register FIFO, plus a log of every shifted value.
    logic [63:0] sr [DEPTH];
    logic [63:0] obs [$];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (bus.fifo_en) begin
            sr[0] <= bus.fifo_d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            obs.push_back(bus.fifo_d);
        end
    end
    assign bus.fifo_q = sr[DEPTH-1];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                         input logic rv, input logic [15:0] ra, input logic [8:0] tid);
        @(negedge clk);
        bus.wr_valid = wv;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rd_valid = rv;
        bus.rd_addr  = ra;
        bus.rd_tid   = tid;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        wv;
        logic [15:0] wa;
        logic [63:0] wd;
        logic        rv;
        logic [15:0] ra;
        logic [8:0]  tid;
        logic        e_en;
        logic [63:0] e_d;
        logic        e_rv;
        logic [63:0] e_rd;
    } vec_t;

    vec_t vt [$];

    function automatic vec_t v(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                               input logic rv, input logic [15:0] ra, input logic [8:0] tid,
                               input logic e_en, input logic [63:0] e_d,
                               input logic e_rv, input logic [63:0] e_rd);
        vec_t r;
        r.wv = wv; r.wa = wa; r.wd = wd;
        r.rv = rv; r.ra = ra; r.tid = tid;
        r.e_en = e_en; r.e_d = e_d;
        r.e_rv = e_rv; r.e_rd = e_rd;
        return r;
    endfunction

    function automatic vec_t idle(input logic e_en, input logic [63:0] e_d);
        return v(1'b0, NA, '0, 1'b0, NA, NT, e_en, e_d, 1'b0, '0);
    endfunction

    function automatic vec_t rdst(input logic [8:0] tid, input logic e_en, input logic [63:0] e_rd);
        return v(1'b0, NA, '0, 1'b1, A_STA, tid, e_en, '0, 1'b1, e_rd);
    endfunction

    // Reference model: values expected to be shifted into the FIFO, in order.
    int          m_count;
    bit          m_ovf;
    bit          m_drop;
    int          m_left;
    logic [63:0] m_pend [$];
    logic [63:0] exp_q [$];

    function automatic logic [63:0] mstat();
        logic [63:0] s;
        s       = '0;
        s[7:0]  = 8'(m_count);
        s[8]    = (m_count == DEPTH);
        s[9]    = (m_left > 0);
        s[10]   = m_ovf;
        s[11]   = m_drop;
        s[12]   = (m_pend.size() != 0);
        return s;
    endfunction

    task automatic mpush(input logic [63:0] d);
        exp_q.push_back(d);
        if (m_count == DEPTH) m_ovf = 1'b1;
        else m_count++;
    endtask

    task automatic mstep(input bit dw, input bit cw, input logic [63:0] d);
        if (cw && d[1]) begin
            m_ovf  = 1'b0;
            m_drop = 1'b0;
        end
        if (m_left > 0) begin
            if (dw) begin
                if (m_pend.size() > 0) m_drop = 1'b1;
                else m_pend.push_back(d);
            end
            m_left--;
            if (m_left == 0) m_count = 0;
        end else if (m_pend.size() > 0) begin
            mpush(m_pend.pop_front());
            if (dw) m_pend.push_back(d);
        end else if (dw) begin
            mpush(d);
        end else if (cw && d[0]) begin
            m_left = DEPTH;
            repeat (DEPTH) exp_q.push_back('0);
        end
    endtask

    task automatic rstep(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                         input logic rv, input logic [15:0] ra, input logic [8:0] tid);
        logic [63:0] erd;
        drive(wv, wa, wd, rv, ra, tid);
        erd = '0;
        if (ra == A_STA) erd = mstat();
        else if (ra == A_DAT) erd = sr[DEPTH-1];
        mstep(wv && wa == A_DAT, wv && wa == A_CTL, wd);
        @(posedge clk);
        #1;
        chk("rnd rsp_valid", 64'(bus.rsp_valid), 64'(rv));
        if (rv) begin
            chk("rnd rsp_tid", 64'(bus.rsp_tid), 64'(tid));
            chk($sformatf("rnd rsp_data addr=%0h", ra), bus.rsp_data, erd);
        end
    endtask

    initial begin
        int pulses;
        int base;
        int mism;
        int n;

        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_valid = 1'b0;
        bus.rd_addr  = '0;
        bus.rd_tid   = '0;

        #1 rst = 1'b1;
        #1;
        chk("reset fifo_en", 64'(bus.fifo_en), 64'h0);
        chk("reset fifo_d", bus.fifo_d, 64'h0);
        chk("reset rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("reset rsp_tid", 64'(bus.rsp_tid), 64'h0);
        chk("reset rsp_data", bus.rsp_data, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i <= 8; i++)
            vt.push_back(v(1'b1, A_DAT, 64'(i), 1'b0, NA, NT, 1'b1, 64'(i), 1'b0, '0));
        vt.push_back(rdst(9'h001, 1'b0, 64'h108));
        vt.push_back(v(1'b1, A_DAT, 64'h9, 1'b1, A_STA, 9'h002, 1'b1, 64'h9, 1'b1, 64'h108));
        vt.push_back(rdst(9'h003, 1'b0, 64'h508));
        vt.push_back(v(1'b1, A_CTL, 64'h2, 1'b1, A_STA, 9'h004, 1'b0, '0, 1'b1, 64'h508));
        vt.push_back(rdst(9'h005, 1'b0, 64'h108));
        vt.push_back(v(1'b1, A_CTL, 64'h1, 1'b0, NA, NT, 1'b1, '0, 1'b0, '0));
        vt.push_back(rdst(9'h006, 1'b1, 64'h308));
        repeat (6) vt.push_back(idle(1'b1, '0));
        vt.push_back(rdst(9'h007, 1'b0, 64'h308));
        vt.push_back(rdst(9'h008, 1'b0, 64'h000));
        vt.push_back(v(1'b1, A_CTL, 64'h1, 1'b0, NA, NT, 1'b1, '0, 1'b0, '0));
        vt.push_back(v(1'b1, A_DAT, 64'hA, 1'b0, NA, NT, 1'b1, '0, 1'b0, '0));
        vt.push_back(v(1'b1, A_DAT, 64'hB, 1'b0, NA, NT, 1'b1, '0, 1'b0, '0));
        vt.push_back(rdst(9'h009, 1'b1, 64'h1A00));
        repeat (4) vt.push_back(idle(1'b1, '0));
        vt.push_back(idle(1'b0, '0));
        vt.push_back(idle(1'b1, 64'hA));
        vt.push_back(rdst(9'h00A, 1'b0, 64'h801));
        vt.push_back(v(1'b0, NA, '0, 1'b1, A_UNM, 9'h1AB, 1'b0, '0, 1'b1, 64'h0));
        vt.push_back(idle(1'b0, '0));
        vt.push_back(v(1'b1, A_CTL, 64'h2, 1'b1, A_CTL, 9'h0C5, 1'b0, '0, 1'b1, 64'h0));
        vt.push_back(v(1'b1, A_UNM, 64'h7, 1'b0, NA, NT, 1'b0, '0, 1'b0, '0));
        vt.push_back(v(1'b1, A_STA, 64'hFFF, 1'b0, NA, NT, 1'b0, '0, 1'b0, '0));
        vt.push_back(rdst(9'h00C, 1'b0, 64'h001));

        foreach (vt[i]) begin
            drive(vt[i].wv, vt[i].wa, vt[i].wd, vt[i].rv, vt[i].ra, vt[i].tid);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d fifo_en", i), 64'(bus.fifo_en), 64'(vt[i].e_en));
            if (vt[i].e_en)
                chk($sformatf("vec%0d fifo_d", i), bus.fifo_d, vt[i].e_d);
            chk($sformatf("vec%0d rsp_valid", i), 64'(bus.rsp_valid), 64'(vt[i].e_rv));
            if (vt[i].e_rv) begin
                chk($sformatf("vec%0d rsp_tid", i), 64'(bus.rsp_tid), 64'(vt[i].tid));
                chk($sformatf("vec%0d rsp_data", i), bus.rsp_data, vt[i].e_rd);
            end
        end

        // Reset in the middle of a flush, with a write parked in pending.
        do_reset();
        drive(1'b1, A_CTL, 64'h1, 1'b0, NA, NT);
        @(posedge clk);
        drive(1'b1, A_DAT, 64'h55, 1'b0, NA, NT);
        @(posedge clk);
        drive(1'b0, NA, '0, 1'b0, NA, NT);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("abort k3 fifo_en", 64'(bus.fifo_en), 64'h1);
        #1 rst = 1'b1;
        #1;
        chk("abort fifo_en immediate", 64'(bus.fifo_en), 64'h0);
        chk("abort fifo_d immediate", bus.fifo_d, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.fifo_en) pulses++;
        end
        chk("abort later pulses", 64'(pulses), 64'h0);
        drive(1'b0, NA, '0, 1'b1, A_STA, 9'h033);
        @(posedge clk);
        #1;
        chk("abort stat rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("abort stat", bus.rsp_data, 64'h0);

        // Random traffic against the reference model.
        do_reset();
        m_count = 0;
        m_ovf   = 1'b0;
        m_drop  = 1'b0;
        m_left  = 0;
        m_pend.delete();
        exp_q.delete();
        base = obs.size();
        for (int k = 0; k < 3000; k++) begin
            logic        wv;
            logic [15:0] wa;
            logic [63:0] wd;
            logic        rv;
            logic [15:0] ra;
            int          op;
            wd = {$urandom, $urandom};
            wv = 1'b0;
            wa = NA;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                wv = 1'b1;
                wa = A_DAT;
            end else if (op == 4) begin
                wv = 1'b1;
                wa = A_CTL;
                wd[0] = ($urandom_range(0, 3) == 0);
            end else if (op == 5) begin
                wv = 1'b1;
                wa = ($urandom_range(0, 1) == 0) ? A_STA : 16'($urandom);
            end
            rv = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: ra = A_DAT;
                1: ra = A_STA;
                2: ra = A_CTL;
                default: ra = 16'($urandom);
            endcase
            rstep(wv, wa, wd, rv, ra, 9'($urandom_range(0, 511)));
        end
        repeat (DEPTH + 4) rstep(1'b0, NA, '0, 1'b1, A_STA, 9'h0AA);

        n = obs.size() - base;
        chk("rnd push count", 64'(n), 64'(exp_q.size()));
        mism = 0;
        for (int i = 0; i < n && i < exp_q.size(); i++)
            if (obs[base+i] !== exp_q[i]) mism++;
        chk("rnd push stream mismatches", 64'(mism), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
